// File: rtl/dram_tester.sv
// Block-RAM test engine: writes P(a), reads it back and compares, then repeats
// with ~P(a). It reports pass/fail, a saturating error count and the first bad beat.
module dram_tester #(
  parameter int unsigned       ADDR_W = 15,
  parameter int unsigned       DATA_W = 8,
  parameter int unsigned       RD_LAT = 1,
  parameter logic [DATA_W-1:0] SEED   = 8'hA5
) (
  input  logic              clka,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [15:0]       err_count,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [DATA_W-1:0] first_err_exp,
  output logic [DATA_W-1:0] first_err_got,
  output logic              wea,
  output logic [ADDR_W-1:0] addra,
  output logic [DATA_W-1:0] dina,
  input  logic [DATA_W-1:0] douta
);

  localparam int unsigned CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam int unsigned PW = (ADDR_W > 2 * DATA_W) ? ADDR_W : 2 * DATA_W;

  typedef enum logic [2:0] {IDLE, WR, RD, FLUSH, DONE} state_t;

  state_t            state, state_n;
  logic              ph, ph_n;
  logic [ADDR_W-1:0] addr, addr_n;
  logic [CW-1:0]     fcnt, fcnt_n;
  logic              wea_n;
  logic [ADDR_W-1:0] addra_n;
  logic [DATA_W-1:0] dina_n;
  logic [DATA_W-1:0] exp_n;
  logic              issue_n;
  logic              kick;

  // Issue stage travels with addra; the RD_LAT-deep line then lines it up with douta.
  logic              iss_v;
  logic [ADDR_W-1:0] iss_a;
  logic [DATA_W-1:0] iss_e;
  logic              line_v [RD_LAT];
  logic [ADDR_W-1:0] line_a [RD_LAT];
  logic [DATA_W-1:0] line_e [RD_LAT];
  logic              mism;

  function automatic logic [DATA_W-1:0] pattern(input logic [ADDR_W-1:0] a);
    logic [PW-1:0] w;
    w = PW'(a);
    return w[DATA_W-1:0] ^ w[2*DATA_W-1:DATA_W] ^ SEED;
  endfunction

  always_comb begin
    state_n = state;
    ph_n    = ph;
    addr_n  = addr;
    fcnt_n  = fcnt;
    wea_n   = 1'b0;
    addra_n = '0;
    dina_n  = '0;
    issue_n = 1'b0;
    kick    = 1'b0;
    exp_n   = ph ? ~pattern(addr) : pattern(addr);
    case (state)
      IDLE, DONE: begin
        if (start) begin
          kick    = 1'b1;
          state_n = WR;
          ph_n    = 1'b0;
          addr_n  = '0;
        end
      end
      WR: begin
        wea_n   = 1'b1;
        addra_n = addr;
        dina_n  = exp_n;
        addr_n  = addr + 1'b1;
        if (addr == '1) state_n = RD;
      end
      RD: begin
        addra_n = addr;
        issue_n = 1'b1;
        addr_n  = addr + 1'b1;
        if (addr == '1) begin
          state_n = FLUSH;
          fcnt_n  = '0;
        end
      end
      FLUSH: begin
        fcnt_n = fcnt + 1'b1;
        if (fcnt == CW'(RD_LAT - 1)) begin
          state_n = ph ? DONE : WR;
          ph_n    = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb mism = line_v[RD_LAT-1] && (douta != line_e[RD_LAT-1]);

  always_ff @(posedge clka) begin
    if (rst) begin
      state <= IDLE;
      ph    <= 1'b0;
      addr  <= '0;
      fcnt  <= '0;
      wea   <= 1'b0;
      addra <= '0;
      dina  <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      iss_v <= 1'b0;
      iss_a <= '0;
      iss_e <= '0;
      for (int unsigned i = 0; i < RD_LAT; i++) begin
        line_v[i] <= 1'b0;
        line_a[i] <= '0;
        line_e[i] <= '0;
      end
    end else begin
      state <= state_n;
      ph    <= ph_n;
      addr  <= addr_n;
      fcnt  <= fcnt_n;
      wea   <= wea_n;
      addra <= addra_n;
      dina  <= dina_n;
      busy  <= (state_n == WR) || (state_n == RD) || (state_n == FLUSH);
      // The last compare lands one edge after DONE is entered, so done follows it.
      done  <= (state == DONE) && !kick;
      iss_v <= issue_n;
      iss_a <= addr;
      iss_e <= exp_n;
      line_v[0] <= iss_v && !kick;
      line_a[0] <= iss_a;
      line_e[0] <= iss_e;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        line_v[i] <= line_v[i-1] && !kick;
        line_a[i] <= line_a[i-1];
        line_e[i] <= line_e[i-1];
      end
    end
  end

  always_ff @(posedge clka) begin
    if (rst || kick) begin
      err_count      <= '0;
      first_err_addr <= '0;
      first_err_exp  <= '0;
      first_err_got  <= '0;
    end else if (mism) begin
      if (err_count != '1) err_count <= err_count + 1'b1;
      if (err_count == '0) begin
        first_err_addr <= line_a[RD_LAT-1];
        first_err_exp  <= line_e[RD_LAT-1];
        first_err_got  <= douta;
      end
    end
  end

  always_comb pass = done && (err_count == '0);

endmodule

// File: tb/tb_dram_tester.sv
// Bench for dram_tester: behavioural RAMs with read corruption, table vectors,
// randomized fault maps against a pass/address-level model, and corner sequences.
module tb_dram_tester;

  logic clka = 1'b0;
  always #5 clka = ~clka;

  logic        rst, start_a, start_b;
  logic        busy_a, done_a, pass_a, wea_a;
  logic [15:0] err_count_a;
  logic [3:0]  first_err_addr_a, addra_a;
  logic [7:0]  first_err_exp_a, first_err_got_a, dina_a, douta_a;
  logic        busy_b, done_b, pass_b, wea_b;
  logic [15:0] err_count_b;
  logic [8:0]  first_err_addr_b, addra_b;
  logic [7:0]  first_err_exp_b, first_err_got_b, dina_b, douta_b;

  dram_tester #(.ADDR_W(4), .DATA_W(8), .RD_LAT(1), .SEED(8'hA5)) dut_a (
    .clka(clka), .rst(rst), .start(start_a), .busy(busy_a), .done(done_a), .pass(pass_a),
    .err_count(err_count_a), .first_err_addr(first_err_addr_a),
    .first_err_exp(first_err_exp_a), .first_err_got(first_err_got_a),
    .wea(wea_a), .addra(addra_a), .dina(dina_a), .douta(douta_a));

  dram_tester #(.ADDR_W(9), .DATA_W(8), .RD_LAT(1), .SEED(8'hA5)) dut_b (
    .clka(clka), .rst(rst), .start(start_b), .busy(busy_b), .done(done_b), .pass(pass_b),
    .err_count(err_count_b), .first_err_addr(first_err_addr_b),
    .first_err_exp(first_err_exp_b), .first_err_got(first_err_got_b),
    .wea(wea_b), .addra(addra_b), .dina(dina_b), .douta(douta_b));

  // RAM A: 1-cycle read, then per-address OR/clear corruption or forced zero.
  logic [7:0] mem_a [16];
  logic [7:0] raw_a;
  logic [3:0] rq_a;
  logic [7:0] or_mask [16];
  logic [7:0] clr_mask [16];
  logic       force0;
  always @(posedge clka) begin
    if (wea_a) mem_a[addra_a] <= dina_a;
    raw_a <= mem_a[addra_a];
    rq_a  <= addra_a;
  end
  always_comb douta_a = force0 ? 8'h00 : ((raw_a | or_mask[rq_a]) & ~clr_mask[rq_a]);

  // RAM B: returns the inverse of every stored byte.
  logic [7:0] mem_b [512];
  logic [7:0] raw_b;
  always @(posedge clka) begin
    if (wea_b) mem_b[addra_b] <= dina_b;
    raw_b <= mem_b[addra_b];
  end
  always_comb douta_b = ~raw_b;

  // Write-beat log for DUT A, restarted whenever a start is accepted.
  logic [3:0] wl_addr [64];
  logic [7:0] wl_data [64];
  int         wcnt = 0;
  always @(posedge clka) begin
    if (start_a && !busy_a && !rst) wcnt <= 0;
    else if (wea_a && wcnt < 64) begin
      wl_addr[wcnt] <= addra_a;
      wl_data[wcnt] <= dina_a;
      wcnt <= wcnt + 1;
    end
  end

  int checks = 0, errors = 0;

  task automatic chk(input string name, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [7:0] pat_of(input int ph, input int a);
    int v;
    v = (a & 'hFF) ^ ((a >> 8) & 'hFF) ^ 'hA5;
    if (ph != 0) v = ~v;
    return 8'(v);
  endfunction

  // Every (pass, address) read is one compare; count those the corrupted RAM spoils.
  task automatic model_a(output int cnt, output int fa, output int fe, output int fg);
    logic [7:0] e, g;
    cnt = 0; fa = 0; fe = 0; fg = 0;
    for (int ph = 0; ph < 2; ph++)
      for (int a = 0; a < 16; a++) begin
        e = pat_of(ph, a);
        g = force0 ? 8'h00 : ((e | or_mask[a]) & ~clr_mask[a]);
        if (g != e) begin
          if (cnt == 0) begin fa = a; fe = e; fg = g; end
          if (cnt < 65535) cnt++;
        end
      end
  endtask

  task automatic clear_faults();
    force0 = 1'b0;
    for (int a = 0; a < 16; a++) begin or_mask[a] = 8'h00; clr_mask[a] = 8'h00; end
  endtask

  task automatic wait_a(input bit noisy, output int cyc);
    cyc = 0;
    while (busy_a && cyc < 2000) begin
      cyc++;
      start_a = noisy && (cyc < 60) && (cyc % 7 == 3);
      @(negedge clka);
    end
    start_a = 1'b0;
    for (int k = 0; k < 10 && !done_a; k++) @(negedge clka);
  endtask

  task automatic run_a(input bit noisy, output int cyc);
    @(negedge clka); start_a = 1'b1;
    @(negedge clka); start_a = 1'b0;
    wait_a(noisy, cyc);
  endtask

  task automatic check_wlog();
    int bad;
    bad = 0;
    chk("wr_beats", wcnt, 32);
    for (int i = 0; i < 32; i++)
      if (wl_addr[i] != 4'(i % 16) || wl_data[i] != pat_of(i / 16, i % 16)) bad++;
    chk("wr_sequence_bad", bad, 0);
  endtask

  task automatic check_idle_zero(input string name);
    chk(name, {busy_a, done_a, pass_a, wea_a, err_count_a, first_err_addr_a,
               first_err_exp_a, first_err_got_a, addra_a, dina_a}, 0);
  endtask

  typedef struct {
    bit force0;
    int stuck_addr;
    int exp_pass, exp_cnt, exp_addr, exp_e, exp_g;
  } vec_t;

  vec_t vecs [3];
  int   cyc, cnt, fa, fe, fg, bad;

  initial begin
    vecs[0] = '{force0: 1'b0, stuck_addr: 5,  exp_pass: 0, exp_cnt: 1,  exp_addr: 5, exp_e: 'hA0, exp_g: 'hA1};
    vecs[1] = '{force0: 1'b1, stuck_addr: -1, exp_pass: 0, exp_cnt: 32, exp_addr: 0, exp_e: 'hA5, exp_g: 'h00};
    vecs[2] = '{force0: 1'b0, stuck_addr: -1, exp_pass: 1, exp_cnt: 0,  exp_addr: 0, exp_e: 'h00, exp_g: 'h00};

    rst = 1'b1; start_a = 1'b0; start_b = 1'b0;
    clear_faults();
    repeat (3) @(negedge clka);
    check_idle_zero("reset_state");
    rst = 1'b0;

    for (int v = 0; v < 3; v++) begin
      clear_faults();
      force0 = vecs[v].force0;
      if (vecs[v].stuck_addr >= 0) or_mask[vecs[v].stuck_addr] = 8'h01;
      run_a(1'b0, cyc);
      chk("vec_busy_cycles", cyc, 66);
      chk("vec_done", done_a, 1);
      chk("vec_pass", pass_a, vecs[v].exp_pass);
      chk("vec_err_count", err_count_a, vecs[v].exp_cnt);
      chk("vec_first_addr", first_err_addr_a, vecs[v].exp_addr);
      chk("vec_first_exp", first_err_exp_a, vecs[v].exp_e);
      chk("vec_first_got", first_err_got_a, vecs[v].exp_g);
      check_wlog();
    end
    chk("dina_a3_pass0", wl_data[3], 'hA6);
    chk("dina_a3_pass1", wl_data[19], 'h59);

    for (int r = 0; r < 4; r++) begin
      clear_faults();
      for (int a = 0; a < 16; a++) begin
        if ($urandom_range(0, 3) == 0) or_mask[a] = 8'($urandom);
        if ($urandom_range(0, 3) == 0) clr_mask[a] = 8'($urandom);
      end
      model_a(cnt, fa, fe, fg);
      repeat ($urandom_range(0, 4)) @(negedge clka);
      run_a(1'b0, cyc);
      chk("rnd_busy_cycles", cyc, 66);
      chk("rnd_pass", pass_a, (cnt == 0) ? 1 : 0);
      chk("rnd_err_count", err_count_a, cnt);
      chk("rnd_first_addr", first_err_addr_a, fa);
      chk("rnd_first_exp", first_err_exp_a, fe);
      chk("rnd_first_got", first_err_got_a, fg);
    end

    // Reset on cycle 20 of a run that is accumulating errors.
    clear_faults();
    force0 = 1'b1;
    @(negedge clka); start_a = 1'b1;
    @(negedge clka); start_a = 1'b0;
    repeat (19) @(negedge clka);
    chk("pre_reset_busy", busy_a, 1);
    rst = 1'b1;
    @(negedge clka);
    check_idle_zero("mid_run_reset");
    rst = 1'b0;
    bad = 0;
    repeat (5) begin
      @(negedge clka);
      if (busy_a || wea_a || done_a) bad++;
    end
    chk("post_reset_idle", bad, 0);
    force0 = 1'b0;
    run_a(1'b0, cyc);
    chk("after_reset_cycles", cyc, 66);
    chk("after_reset_pass", pass_a, 1);

    // Extra start pulses while busy.
    run_a(1'b1, cyc);
    chk("noisy_cycles", cyc, 66);
    chk("noisy_pass", pass_a, 1);
    check_wlog();

    // Start in DONE clears results on that edge.
    force0 = 1'b1;
    run_a(1'b0, cyc);
    chk("done_restart_pre_err", err_count_a, 32);
    force0 = 1'b0;
    @(negedge clka); start_a = 1'b1;
    @(negedge clka); start_a = 1'b0;
    chk("restart_clear", {busy_a, done_a, pass_a, err_count_a, first_err_exp_a}, 64'h4_0000_00);
    wait_a(1'b0, cyc);
    chk("restart_cycles", cyc, 66);
    chk("restart_pass", pass_a, 1);

    // start on the same edge as rst: rst wins.
    @(negedge clka); rst = 1'b1; start_a = 1'b1;
    @(negedge clka); rst = 1'b0; start_a = 1'b0;
    chk("rst_beats_start", busy_a, 0);
    @(negedge clka);
    chk("rst_beats_start_next", busy_a, 0);

    // 512-word part with every read inverted: first_* must keep the first capture.
    @(negedge clka); start_b = 1'b1;
    @(negedge clka); start_b = 1'b0;
    cyc = 0;
    while (busy_b && cyc < 5000) begin cyc++; @(negedge clka); end
    for (int k = 0; k < 10 && !done_b; k++) @(negedge clka);
    chk("b_busy_cycles", cyc, 2050);
    chk("b_done", done_b, 1);
    chk("b_pass", pass_b, 0);
    chk("b_err_count", err_count_b, 1024);
    chk("b_first_addr", first_err_addr_b, 0);
    chk("b_first_exp", first_err_exp_b, 'hA5);
    chk("b_first_got", first_err_got_b, 'h5A);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
